// File: rtl/add_32_arbiter_pkg.sv
// Shared definitions for the add_32 arbiter slice: word width, operation
// encoding and the output-stage state type.
package add_32_arbiter_pkg;

    localparam int WORD_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/add_32_arbiter_cla.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups whose
// group generate/propagate terms chain the block carries.
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  blk_c;

    // Per-bit generate/propagate, in-group lookahead carries, then group carry chain
    always_comb begin
        g        = a & b;
        p        = a ^ b;
        c        = '0;
        blk_c    = '0;
        blk_c[0] = cin;
        for (int blk = 0; blk < 8; blk++) begin
            c[4*blk]   = blk_c[blk];
            c[4*blk+1] = g[4*blk] | (p[4*blk] & blk_c[blk]);
            c[4*blk+2] = g[4*blk+1] | (p[4*blk+1] & g[4*blk])
                       | (p[4*blk+1] & p[4*blk] & blk_c[blk]);
            c[4*blk+3] = g[4*blk+2] | (p[4*blk+2] & g[4*blk+1])
                       | (p[4*blk+2] & p[4*blk+1] & g[4*blk])
                       | (p[4*blk+2] & p[4*blk+1] & p[4*blk] & blk_c[blk]);
            blk_c[blk+1] = g[4*blk+3] | (p[4*blk+3] & g[4*blk+2])
                         | (p[4*blk+3] & p[4*blk+2] & g[4*blk+1])
                         | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & g[4*blk])
                         | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & p[4*blk] & blk_c[blk]);
        end
        sum = p ^ c;
    end

endmodule

// File: rtl/add_32_arbiter_rr.sv
// Round-robin arbiter: starting one past the last winner, pick the first
// requester with valid set. Purely combinational.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt,
    output logic            any_valid
);

    int             idx_int;
    logic [IDW-1:0] idx;

    // Walk the requesters from ptr+1 around to ptr itself and keep the first hit
    always_comb begin
        grant     = '0;
        gnt       = '0;
        any_valid = 1'b0;
        idx_int   = 0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_int = (int'(ptr) + k) % NREQ;
            idx     = IDW'(idx_int);
            if (!any_valid && valid[idx]) begin
                any_valid  = 1'b1;
                gnt        = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_32_arbiter.sv
// Shares one add_32 between NREQ requesters. A round-robin arbiter picks the
// operand set, the adder computes x+y or x-y, and the result lands in a
// one-entry output register with valid/ready backpressure.
module add_32_arbiter
    import add_32_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_x,
    input  logic [NREQ*32-1:0]   req_y,
    input  logic [NREQ-1:0]      req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum
);

    out_state_t        state;
    out_state_t        state_next;
    logic [IDW-1:0]    ptr;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    gnt;
    logic              any_valid;
    logic              accept;
    logic              transfer;
    logic [WORD_W-1:0] x_gnt;
    logic [WORD_W-1:0] y_gnt;
    logic              sub_gnt;
    logic [WORD_W-1:0] y_cond;
    logic [WORD_W-1:0] sum;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .gnt       (gnt),
        .any_valid (any_valid)
    );

    assign rsp_valid = (state == FULL);
    assign accept    = !rsp_valid || rsp_ready;
    assign transfer  = any_valid && accept;
    assign req_ready = accept ? grant : '0;

    // Select the winner's operands and condition y/carry-in for subtraction
    always_comb begin
        x_gnt   = '0;
        y_gnt   = '0;
        sub_gnt = OP_ADD;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                x_gnt   = req_x[i*WORD_W +: WORD_W];
                y_gnt   = req_y[i*WORD_W +: WORD_W];
                sub_gnt = req_sub[i];
            end
        end
        y_cond = y_gnt ^ {WORD_W{sub_gnt == OP_SUB}};
    end

    add_32 u_add (
        .a   (x_gnt),
        .b   (y_cond),
        .cin (sub_gnt == OP_SUB),
        .sum (sum)
    );

    // Output stage: fill on a transfer, drain when consumed with nothing new arriving
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (transfer) state_next = FULL;
            FULL:  if (rsp_ready && !transfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // State register; reset discards any held result
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= EMPTY;
        else        state <= state_next;
    end

    // Priority pointer and result register advance only on a transfer
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            ptr     <= IDW'(NREQ - 1);
            rsp_id  <= '0;
            rsp_sum <= '0;
        end else if (transfer) begin
            ptr     <= gnt;
            rsp_id  <= gnt;
            rsp_sum <= sum;
        end
    end

endmodule

// File: tb/tb_add_32_arbiter.sv
// Directed bench for add_32_arbiter with NREQ=2: arithmetic, round-robin
// order, backpressure stalls and asynchronous reset.
module tb_add_32_arbiter;

    logic        clock;
    logic        clear;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_x;
    logic [63:0] req_y;
    logic [1:0]  req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_sum;

    int checks;
    int errors;

    add_32_arbiter #(
        .NREQ (2),
        .IDW  (1)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic setOperand(input int i, input logic [31:0] x,
                              input logic [31:0] y, input logic sub);
        req_x[i*32 +: 32] = x;
        req_y[i*32 +: 32] = y;
        req_sub[i]        = sub;
    endtask

    // Drive inputs on the falling edge and let combinational outputs settle
    task automatic applyStimulus(input logic [1:0] valid, input logic ready);
        @(negedge clock);
        req_valid = valid;
        rsp_ready = ready;
        #1;
    endtask

    task automatic afterEdge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clear     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_rsp_sum", rsp_sum, 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        clear = 1'b1;

        // 1: 5 + 3 from requester 0
        setOperand(0, 32'd5, 32'd3, 1'b0);
        applyStimulus(2'b01, 1'b1);
        checkOutput("t1_req_ready", 32'(req_ready), 32'd1);
        afterEdge();
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t1_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("t1_rsp_sum", rsp_sum, 32'd8);

        // 2: 0 - 1 wraps, then 0xFFFFFFFF + 1 wraps
        setOperand(1, 32'd0, 32'd1, 1'b1);
        applyStimulus(2'b10, 1'b1);
        checkOutput("t2a_req_ready", 32'(req_ready), 32'd2);
        afterEdge();
        checkOutput("t2a_rsp_id", 32'(rsp_id), 32'd1);
        checkOutput("t2a_rsp_sum", rsp_sum, 32'hFFFF_FFFF);
        setOperand(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        applyStimulus(2'b01, 1'b1);
        afterEdge();
        checkOutput("t2b_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("t2b_rsp_sum", rsp_sum, 32'd0);
        checkOutput("t2b_rsp_valid", 32'(rsp_valid), 32'd1);

        // Move the pointer to 1 so the next contention starts at requester 0
        setOperand(1, 32'd10, 32'd4, 1'b1);
        applyStimulus(2'b10, 1'b1);
        afterEdge();
        checkOutput("t2c_rsp_sum", rsp_sum, 32'd6);

        // 3: both valid for 4 cycles -> 0,1,0,1
        setOperand(0, 32'd100, 32'd1, 1'b0);
        setOperand(1, 32'd50, 32'd20, 1'b1);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(2'b11, 1'b1);
            checkOutput($sformatf("t3_req_ready_%0d", n), 32'(req_ready),
                        (n % 2 == 0) ? 32'd1 : 32'd2);
            afterEdge();
            checkOutput($sformatf("t3_rsp_id_%0d", n), 32'(rsp_id), 32'(n % 2));
            checkOutput($sformatf("t3_rsp_sum_%0d", n), rsp_sum,
                        (n % 2 == 0) ? 32'd101 : 32'd30);
        end

        // 4: stall while FULL; requester 0 drops its request during the stall
        for (int n = 0; n < 3; n++) begin
            applyStimulus((n == 1) ? 2'b10 : 2'b11, 1'b0);
            checkOutput($sformatf("t4_req_ready_%0d", n), 32'(req_ready), 32'd0);
            afterEdge();
            checkOutput($sformatf("t4_rsp_valid_%0d", n), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("t4_rsp_id_%0d", n), 32'(rsp_id), 32'd1);
            checkOutput($sformatf("t4_rsp_sum_%0d", n), rsp_sum, 32'd30);
        end
        applyStimulus(2'b01, 1'b1);
        checkOutput("t4_reload_req_ready", 32'(req_ready), 32'd1);
        checkOutput("t4_reload_valid_before", 32'(rsp_valid), 32'd1);
        afterEdge();
        checkOutput("t4_reload_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t4_reload_id", 32'(rsp_id), 32'd0);
        checkOutput("t4_reload_sum", rsp_sum, 32'd101);

        // Drain to EMPTY, then accept while the consumer is not ready
        applyStimulus(2'b00, 1'b1);
        checkOutput("t4_drain_req_ready", 32'(req_ready), 32'd0);
        afterEdge();
        checkOutput("t4_drain_valid", 32'(rsp_valid), 32'd0);
        applyStimulus(2'b10, 1'b0);
        checkOutput("t4_empty_req_ready", 32'(req_ready), 32'd2);
        afterEdge();
        checkOutput("t4_empty_fill_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t4_empty_fill_id", 32'(rsp_id), 32'd1);

        // 5: asynchronous reset mid-cycle while FULL
        applyStimulus(2'b00, 1'b0);
        #2;
        clear = 1'b0;
        #1;
        checkOutput("t5_clear_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t5_clear_sum", rsp_sum, 32'd0);
        checkOutput("t5_clear_id", 32'(rsp_id), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        applyStimulus(2'b11, 1'b1);
        checkOutput("t5_req_ready", 32'(req_ready), 32'd1);
        afterEdge();
        checkOutput("t5_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("t5_rsp_sum", rsp_sum, 32'd101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
